// File: rtl/multi_read_port_lutram.sv
// Multi-read-port LUTRAM: one byte-masked write port, NUM_READ_PORT registered read ports,
// built-in zeroing sweep after reset. Optional write-first forwarding: MULTI_READ_PORT_LUTRAM_WRITE_FORWARD_EN.
module multi_read_port_lutram #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int NUM_READ_PORT             = 2,
  parameter int BYTE_LEN_IN_BITS          = 8,
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
  input  logic                                           clk_in,
  input  logic                                           reset_in,
  output logic                                           init_done_out,
  input  logic [WRITE_MASK_LEN-1:0]                      write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]               write_set_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]           write_entry_in,
  input  logic [NUM_READ_PORT-1:0]                       read_en_in,
  input  logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0] read_set_addr_in,
  output logic [NUM_READ_PORT*SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
  output logic [NUM_READ_PORT-1:0]                       read_valid_out
);

  localparam int E = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int W = SET_PTR_WIDTH_IN_BITS;
  localparam int P = NUM_READ_PORT;
  localparam int M = WRITE_MASK_LEN;
  localparam int B = BYTE_LEN_IN_BITS;
  localparam logic [W:0]   NUM_SET_EXT = (W+1)'(NUM_SET);
  localparam logic [W-1:0] LAST_SET    = W'(NUM_SET - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t          state_r;
  logic [W-1:0]    ptr_r;
  logic            init_done_r;
  logic [E-1:0]    mem_r [NUM_SET];
  logic            wr_fire_s;
  logic [W-1:0]    rd_addr_s [P];
  logic [E-1:0]    rd_data_s [P];
  logic [P*E-1:0]  read_entry_r;
  logic [P-1:0]    read_valid_r;

  function automatic logic [E-1:0] merge_bytes(input logic [E-1:0] old_v,
                                               input logic [E-1:0] new_v,
                                               input logic [M-1:0] mask);
    logic [E-1:0] res;
    res = old_v;
    for (int i = 0; i < M; i++) begin
      res[i*B +: B] = mask[i] ? new_v[i*B +: B] : old_v[i*B +: B];
    end
    return res;
  endfunction

  function automatic logic in_range(input logic [W-1:0] addr);
    return ({1'b0, addr} < NUM_SET_EXT);
  endfunction

  // Qualify user writes: only in READY, non-empty mask, legal address
  always_comb begin
    wr_fire_s = 1'b0;
    if ((state_r == ST_READY) && (|write_en_in) && in_range(write_set_addr_in)) begin
      wr_fire_s = 1'b1;
    end else begin
      wr_fire_s = 1'b0;
    end
  end

  // Init sweep controller
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r     <= ST_INIT;
      ptr_r       <= {W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (ptr_r == LAST_SET) begin
            state_r     <= ST_READY;
            ptr_r       <= {W{1'b0}};
            init_done_r <= 1'b1;
          end else begin
            ptr_r <= ptr_r + W'(1);
          end
        end
        ST_READY: begin
          state_r     <= ST_READY;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          ptr_r       <= {W{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: sweep zeroing in INIT, masked user writes in READY (no reset on contents)
  always_ff @(posedge clk_in) begin
    if (!reset_in && (state_r == ST_INIT)) begin
      mem_r[ptr_r] <= {E{1'b0}};
    end else if (!reset_in && wr_fire_s) begin
      mem_r[write_set_addr_in] <= merge_bytes(mem_r[write_set_addr_in], write_entry_in, write_en_in);
    end
  end

  // Per-port read data before the output register
  always_comb begin
    for (int p = 0; p < P; p++) begin
      rd_addr_s[p] = read_set_addr_in[p*W +: W];
      rd_data_s[p] = {E{1'b0}};
    end
    for (int p = 0; p < P; p++) begin
      if (!in_range(rd_addr_s[p])) begin
        rd_data_s[p] = {E{1'b0}};
      end else begin
`ifdef MULTI_READ_PORT_LUTRAM_WRITE_FORWARD_EN
        // Write-first: merge the in-flight write into a same-set read
        if (wr_fire_s && (write_set_addr_in == rd_addr_s[p])) begin
          rd_data_s[p] = merge_bytes(mem_r[rd_addr_s[p]], write_entry_in, write_en_in);
        end else begin
          rd_data_s[p] = mem_r[rd_addr_s[p]];
        end
`else
        rd_data_s[p] = mem_r[rd_addr_s[p]];
`endif
      end
    end
  end

  // Registered read outputs; disabled ports hold their data
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      read_entry_r <= {(P*E){1'b0}};
      read_valid_r <= {P{1'b0}};
    end else begin
      for (int p = 0; p < P; p++) begin
        if ((state_r == ST_READY) && read_en_in[p]) begin
          read_valid_r[p]       <= 1'b1;
          read_entry_r[p*E +: E] <= rd_data_s[p];
        end else begin
          read_valid_r[p] <= 1'b0;
        end
      end
    end
  end

  assign init_done_out  = init_done_r;
  assign read_entry_out = read_entry_r;
  assign read_valid_out = read_valid_r;

endmodule
